// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: round controller for the number-guessing game.
// It draws a pseudo-random target for each round from a free-running 10-bit LFSR.
// It grades the player's guesses against that target and counts rounds and wrong guesses.
// An optional per-round countdown is built only when ROUND_TIMER_EN is defined.
// Without ROUND_TIMER_EN, timer reads a constant 127.
module guess_round_ctrl #(
    parameter int         CLK_HZ    = 50000000,
    parameter int         TIME_D1   = 30,
    parameter int         TIME_D2   = 60,
    parameter int         TIME_D3   = 90,
    parameter logic [9:0] LFSR_SEED = 10'h001
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       confirmButton,
    input  logic [9:0] guess,
    input  logic [1:0] Max_digit,
    input  logic [1:0] WINorLOSE,
    output logic [3:0] round,
    output logic [2:0] incorrect_guesses,
    output logic [6:0] timer,
    output logic [1:0] hint,
    output logic       busy
);

    typedef enum logic [2:0] {
        SETTLE = 3'd0,
        DRAW   = 3'd1,
        PLAY   = 3'd2,
        CHECK  = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [1:0] HINT_NONE = 2'b00;
    localparam logic [1:0] HINT_LOW  = 2'b01;
    localparam logic [1:0] HINT_HIGH = 2'b10;
    localparam logic [1:0] HINT_OK   = 2'b11;

`ifdef ROUND_TIMER_EN
    localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [6:0]      TIMER_INIT = 7'(TIME_D1);
`else
    localparam logic [6:0]      TIMER_INIT = 7'd127;
`endif

    // Exclusive upper bound of the target range for a difficulty; 0 is treated as 1 digit.
    function automatic logic [9:0] limit_of(input logic [1:0] md);
        case (md)
            2'd2:    limit_of = 10'd100;
            2'd3:    limit_of = 10'd1000;
            default: limit_of = 10'd10;
        endcase
    endfunction

`ifdef ROUND_TIMER_EN
    // Round length in seconds for a difficulty.
    function automatic logic [6:0] reload_of(input logic [1:0] md);
        case (md)
            2'd2:    reload_of = 7'(TIME_D2);
            2'd3:    reload_of = 7'(TIME_D3);
            default: reload_of = 7'(TIME_D1);
        endcase
    endfunction
`endif

    state_t      state_q, state_d;
    logic        settle_cnt_q, settle_cnt_d;
    logic [9:0]  lfsr_q, lfsr_d;
    logic [1:0]  maxd_q, maxd_d;
    logic        conf_prev_q, conf_prev_d;
    logic [9:0]  guess_cap_q, guess_cap_d;
    logic [9:0]  target_q, target_d;
    logic [3:0]  round_q, round_d;
    logic [2:0]  incorrect_q, incorrect_d;
    logic [6:0]  timer_q, timer_d;
    logic [1:0]  hint_q, hint_d;
    logic        busy_q, busy_d;
`ifdef ROUND_TIMER_EN
    logic [PW-1:0] presc_q, presc_d;
`endif

    logic [9:0]  candidate;
    logic [9:0]  limit;
    logic        conf_edge;

    assign candidate = lfsr_q - 10'd1;
    assign limit     = limit_of(maxd_q);
    assign conf_edge = confirmButton & ~conf_prev_q;

    // Next-state and next-output computation for the round controller.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        lfsr_d       = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        maxd_d       = Max_digit;
        conf_prev_d  = confirmButton;
        guess_cap_d  = guess_cap_q;
        target_d     = target_q;
        round_d      = round_q;
        incorrect_d  = incorrect_q;
        timer_d      = timer_q;
        hint_d       = hint_q;
`ifdef ROUND_TIMER_EN
        presc_d      = presc_q;
        // The countdown runs only while a guess may be pending.
        if (state_q == PLAY || state_q == CHECK) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (timer_q != 7'd0) begin
                    timer_d = timer_q - 7'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
`else
        timer_d      = 7'd127;
`endif

        case (state_q)
            SETTLE: begin
                // Two cycles let maxd_q catch up with a difficulty change made right after a win.
                if (settle_cnt_q) begin
                    settle_cnt_d = 1'b0;
                    state_d      = DRAW;
                end else begin
                    settle_cnt_d = 1'b1;
                end
            end
            DRAW: begin
                if (candidate < limit) begin
                    target_d = candidate;
`ifdef ROUND_TIMER_EN
                    timer_d  = reload_of(maxd_q);
                    presc_d  = '0;
`endif
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if (conf_edge && (timer_q != 7'd0)) begin
                    guess_cap_d = guess;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (guess_cap_q >= limit) begin
                    hint_d  = HINT_NONE;
                    state_d = PLAY;
                end else if (guess_cap_q != target_q) begin
                    hint_d      = (guess_cap_q < target_q) ? HINT_LOW : HINT_HIGH;
                    incorrect_d = (incorrect_q == 3'd7) ? 3'd7 : incorrect_q + 3'd1;
                    state_d     = PLAY;
                end else begin
                    hint_d       = HINT_OK;
                    round_d      = (round_q == 4'd15) ? 4'd15 : round_q + 4'd1;
                    incorrect_d  = 3'd0;
                    settle_cnt_d = 1'b0;
                    state_d      = SETTLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = SETTLE;
            end
        endcase

        if (WINorLOSE != 2'b11) begin
            state_d = HALT;
        end

        busy_d = (state_d == SETTLE) || (state_d == DRAW);
    end

    // State, datapath and registered outputs; restart clears everything asynchronously.
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            state_q      <= SETTLE;
            settle_cnt_q <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            maxd_q       <= 2'd1;
            conf_prev_q  <= 1'b0;
            guess_cap_q  <= 10'd0;
            target_q     <= 10'd0;
            round_q      <= 4'd1;
            incorrect_q  <= 3'd0;
            timer_q      <= TIMER_INIT;
            hint_q       <= HINT_NONE;
            busy_q       <= 1'b1;
`ifdef ROUND_TIMER_EN
            presc_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            lfsr_q       <= lfsr_d;
            maxd_q       <= maxd_d;
            conf_prev_q  <= conf_prev_d;
            guess_cap_q  <= guess_cap_d;
            target_q     <= target_d;
            round_q      <= round_d;
            incorrect_q  <= incorrect_d;
            timer_q      <= timer_d;
            hint_q       <= hint_d;
            busy_q       <= busy_d;
`ifdef ROUND_TIMER_EN
            presc_q      <= presc_d;
`endif
        end
    end

    assign round             = round_q;
    assign incorrect_guesses = incorrect_q;
    assign timer             = timer_q;
    assign hint              = hint_q;
    assign busy              = busy_q;

endmodule
